ifu_fetch: RTL

Instruction fetch stage sitting directly upstream of the decode stage in the multi-cycle core.
- Holds the PC and issues one instruction read per instruction over a simple request/response memory port.
- Generates the sign-extended immediate.
- Hands {inst, imm, pc} to decode with a one-cycle valid pulse.
- Next fetch starts only when writeback returns the next PC, so at most one instruction is in flight.

---
 rtl/ifu_fetch.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage feeding decode.
// One fetch in flight; writeback supplies every next PC.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_pc_valid,
    input  logic [31:0] i_dnpc,
    output logic        o_mem_req_valid,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_req_ready,
    input  logic        i_mem_resp_valid,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_resp_err,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_imm,
    output logic [31:0] o_pc,
    output logic        o_fault
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DONE,
        S_IDLE
    } state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [7:0]  r_cnt;
    logic        r_valid;
    logic        r_fault;
    logic [31:0] r_inst;
    logic [31:0] r_imm;
    logic [31:0] r_out_pc;

    logic [6:0]  w_opc;
    logic        w_sign;
    logic [31:0] w_imm;
    logic [7:0]  w_cnt_next;
    logic        w_timeout;

    assign w_opc      = i_mem_rdata[6:0];
    assign w_sign     = i_mem_rdata[31];
    assign w_cnt_next = r_cnt + 8'd1;
    // The cycle whose count reaches the limit is the last chance for a response.
    assign w_timeout  = (w_cnt_next == LP_TIMEOUT);

    // Immediate decode of the incoming read data, selected by opcode.
    always_comb begin
        w_imm = {25'b0, i_mem_rdata[31:25]};
        case (w_opc)
            OP_OPIMM, OP_JALR, OP_LOAD, OP_SYSTEM: begin
                w_imm = {{20{w_sign}}, i_mem_rdata[31:20]};
            end
            OP_LUI, OP_AUIPC: begin
                w_imm = {i_mem_rdata[31:12], 12'b0};
            end
            OP_JAL: begin
                w_imm = {{11{w_sign}}, i_mem_rdata[31],
                         i_mem_rdata[19:12], i_mem_rdata[20],
                         i_mem_rdata[30:21], 1'b0};
            end
            OP_STORE: begin
                w_imm = {{20{w_sign}}, i_mem_rdata[31:25],
                         i_mem_rdata[11:7]};
            end
            OP_BRANCH: begin
                w_imm = {{19{w_sign}}, i_mem_rdata[31],
                         i_mem_rdata[7], i_mem_rdata[30:25],
                         i_mem_rdata[11:8], 1'b0};
            end
            default: begin
                w_imm = {25'b0, i_mem_rdata[31:25]};
            end
        endcase
    end

    // Fetch FSM with registered delivery bundle and one-cycle valid pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_cnt    <= 8'd0;
            r_valid  <= 1'b0;
            r_fault  <= 1'b0;
            r_inst   <= 32'd0;
            r_imm    <= 32'd0;
            r_out_pc <= 32'd0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_REQ: begin
                    if (i_mem_req_ready) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 8'd0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_next;
                    if (i_mem_resp_valid) begin
                        r_inst   <= i_mem_resp_err ? 32'd0 : i_mem_rdata;
                        r_imm    <= i_mem_resp_err ? 32'd0 : w_imm;
                        r_out_pc <= r_pc;
                        r_fault  <= i_mem_resp_err;
                        r_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (w_timeout) begin
                        r_inst   <= 32'd0;
                        r_imm    <= 32'd0;
                        r_out_pc <= r_pc;
                        r_fault  <= 1'b1;
                        r_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (i_pc_valid) begin
                        r_pc    <= i_dnpc;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

    assign o_mem_req_valid = (r_state == S_REQ);
    assign o_mem_addr      = r_pc;
    assign o_valid         = r_valid;
    assign o_inst          = r_inst;
    assign o_imm           = r_imm;
    assign o_pc            = r_out_pc;
    assign o_fault         = r_fault;

endmodule
